imem_loader: RTL and testbench

Program loader that fills the byte-addressed instruction memory from a byte stream before the MIPS core runs. It accepts bytes over a valid/ready handshake and issues one registered byte write per accepted byte into the 1024-byte instruction store. Byte order is big-endian: stream byte k lands at address base+k, so instruction fetch reads mem[a..a+3] MSB-first. A trailing checksum byte validates the image, and the core is held in stall while loading.

---
 rtl/imem_loader_if.sv | 14 +
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream port into the instruction-memory loader.
//
// Handshake: a byte transfers on every rising clock edge where s_valid and
// s_ready are both high. The source holds s_valid/s_data stable until that
// edge; s_ready never depends combinationally on s_valid, and a transfer is
// never taken back once the edge has passed.
interface imem_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/imem_loader.sv
// Program loader: streams an image into the byte-addressed instruction
// memory (big-endian, byte k at base+k, wrapping modulo DEPTH), validates a
// trailing checksum byte and holds the core in stall while loading.
module imem_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  imem_loader_if.slave      s,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_stall,
  output logic              done,
  output logic              ok,
  output logic              err_len,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [7:0]        sum;
  logic [7:0]        chk_sum;
  logic              ready_d;
  logic              hs;
  logic              last_byte;

  // s_ready comes from state only, so it never loops back from s_valid.
  assign hs        = s.s_valid & ready_d;
  assign last_byte = (cnt == (len_q - ONE));
  assign chk_sum   = sum + s.s_data;
  assign s.s_ready = ready_d;
  assign busy      = (state != IDLE);
  assign cpu_stall = busy;
  assign dbg_state = state;

  // State register; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and stream-ready decode.
  always_comb begin
    state_d = state;
    ready_d = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length > DEPTH_L)   state_d = IDLE;
          else if (length == '0)  state_d = CHECK;
          else                    state_d = LOAD;
        end
      end
      LOAD: begin
        ready_d = 1'b1;
        if (s.s_valid && last_byte) state_d = CHECK;
      end
      CHECK: begin
        ready_d = 1'b1;
        if (s.s_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: parameter latch, registered byte write, running sum, result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      ok        <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            len_q   <= length;
            cnt     <= '0;
            sum     <= '0;
            ok      <= 1'b0;
            err_len <= 1'b0;
            // An oversized image is refused outright: flag it and end the load.
            if (length > DEPTH_L) begin
              err_len <= 1'b1;
              done    <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (hs) begin
            mem_we    <= 1'b1;
            mem_addr  <= base_q + cnt[ADDR_W-1:0];
            mem_wdata <= s.s_data;
            sum       <= sum + s.s_data;
            cnt       <= cnt + ONE;
          end
        end
        CHECK: begin
          // Checksum byte is consumed but never written to memory.
          if (hs) begin
            ok   <= (chk_sum == 8'h00);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load scenarios plus hand-written corner
// sequences (start while busy, reset mid-load). Expected memory writes go
// into exp_q as bytes are offered and are compared against observed writes.
module tb_imem_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] base_addr;
  logic [10:0] length;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy, cpu_stall, done, ok, err_len;
  logic [1:0] dbg_state;

  imem_loader_if sif();

  imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .s         (sif),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .cpu_stall (cpu_stall),
    .done      (done),
    .ok        (ok),
    .err_len   (err_len),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model and write monitor ----------------
  logic [7:0]  mem [0:1023];
  logic [49:0] got_q[$];          // {cycle, addr, data} of each observed write

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_q.push_back({cyc, mem_addr, mem_wdata});
      mem[mem_addr] = mem_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];          // {addr, data} of each required write
  int n_checks = 0;
  int n_fail   = 0;
  int got_rd   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drain();
    logic [49:0] g;
    logic [17:0] e;
    while (got_rd < got_q.size()) begin
      g = got_q[got_rd];
      got_rd++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, no write required", g[17:8], g[7:0]);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {22'd0, g[17:8]}, {22'd0, e[17:8]});
        check("write_data", {24'd0, g[7:0]}, {24'd0, e[7:0]});
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"},   sif.s_ready, 0);
    check({tag, "_mem_we"},    mem_we, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_cpu_stall"}, cpu_stall, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_ok"},        ok, 0);
    check({tag, "_err_len"},   err_len, 0);
  endtask

  // ---------------- driver tasks ----------------
  logic [7:0] img_basic [8];
  logic [7:0] img_wrap  [4];

  function automatic logic [7:0] byte_for(input int mode, input int i);
    if (mode == 0)      return img_basic[i % 8];
    else if (mode == 1) return img_wrap[i % 4];
    else                return 8'($urandom_range(0, 255));
  endfunction

  // Present start for one edge; returns #1 after the accepting edge.
  task automatic start_load(input logic [9:0] b, input logic [10:0] len);
    start     = 1'b1;
    base_addr = b;
    length    = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte and return #1 after the edge that took it.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) begin
      sif.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    sif.s_valid = 1'b1;
    sif.s_data  = b;
    while (sif.s_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL s_ready_timeout: s_ready still %b after 50 cycles, required 1", sif.s_ready);
    end
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [9:0]  base;
    logic [10:0] len;
    int          mode;      // 0 basic image, 1 wrap image, 2 random bytes
    bit          gaps;      // idle cycle before every byte
    bit          fixed;     // use chk below, else the correct checksum
    logic [7:0]  chk;
    bit          exp_ok;
    bit          exp_err;
    int          exp_wr;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] sum = 8'h00;
    logic [7:0] b, chk;
    int g0 = got_q.size();
    logic [49:0] gf, gl;
    start_load(v.base, v.len);
    if (v.exp_err) begin
      check({tag, "_rej_done"}, done, 1);
      check({tag, "_rej_err_len"}, err_len, 1);
      check({tag, "_rej_ok"}, ok, 0);
      check({tag, "_rej_busy"}, busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_rej_busy_later"}, busy, 0);
      check({tag, "_rej_done_pulse"}, done, 0);
      check({tag, "_rej_err_held"}, err_len, 1);
    end else begin
      check({tag, "_busy_after_start"}, busy, 1);
      check({tag, "_stall_after_start"}, cpu_stall, 1);
      check({tag, "_ready_after_start"}, sif.s_ready, 1);
      for (int i = 0; i < int'(v.len); i++) begin
        b = byte_for(v.mode, i);
        sum += b;
        exp_q.push_back({10'(v.base + 10'(i)), b});
        send_byte(b, v.gaps);
      end
      chk = v.fixed ? v.chk : 8'(8'h00 - sum);
      send_byte(chk, v.gaps);
      check({tag, "_done"}, done, 1);
      check({tag, "_ok"}, ok, {31'd0, v.exp_ok});
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_ready_end"}, sif.s_ready, 0);
      check({tag, "_err_len"}, err_len, 0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_ok_held"}, ok, {31'd0, v.exp_ok});
    end
    drain();
    check({tag, "_write_count"}, 32'(got_q.size() - g0), 32'(v.exp_wr));
    check({tag, "_exp_q_empty"}, 32'(exp_q.size()), 0);
    if (!v.gaps && v.exp_wr > 1) begin
      gf = got_q[g0];
      gl = got_q[got_q.size() - 1];
      check({tag, "_back_to_back"}, gl[49:18] - gf[49:18], 32'(v.exp_wr - 1));
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [7:0] saved103;
    logic [7:0] bb;
    int g0;

    img_basic = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    img_wrap  = '{8'h11, 8'h22, 8'h33, 8'h44};

    //            base  len   mode gaps fixed chk    ok err writes
    vecs[0] = '{10'd0,    11'd8,    0, 1'b0, 1'b1, 8'h59, 1'b1, 1'b0, 8};
    vecs[1] = '{10'd0,    11'd8,    0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8};
    vecs[2] = '{10'd1022, 11'd4,    1, 1'b1, 1'b1, 8'h56, 1'b1, 1'b0, 4};
    vecs[3] = '{10'd5,    11'd1025, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0};
    vecs[4] = '{10'd9,    11'd0,    2, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0};
    vecs[5] = '{10'd37,   11'd1024, 2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1024};
    vecs[6] = '{10'd1023, 11'd1,    1, 1'b0, 1'b1, 8'hEF, 1'b1, 1'b0, 1};
    vecs[7] = '{10'd600,  11'd5,    2, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5};
    vecs[8] = '{10'd1020, 11'd6,    2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6};

    rst_n       = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    length      = '0;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    #3;
    check_reset_vals("reset");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("after_reset");

    for (int k = 0; k < 9; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
      if (k == 0)
        check("word_at_0", {mem[0], mem[1], mem[2], mem[3]}, 32'h20080005);
      if (k == 2) begin
        check("wrap_mem_1022", mem[1022], 8'h11);
        check("wrap_mem_1", mem[1], 8'h44);
      end
    end

    // start while busy: must not disturb the load already in progress
    g0 = got_q.size();
    start_load(10'd0, 11'd8);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({10'(i), img_basic[i]});
      send_byte(img_basic[i], 1'b0);
    end
    start     = 1'b1;
    base_addr = 10'd500;
    length    = 11'd3;
    exp_q.push_back({10'd3, img_basic[3]});
    send_byte(img_basic[3], 1'b0);
    start = 1'b0;
    check("busy_start_ignored_busy", busy, 1);
    for (int i = 4; i < 8; i++) begin
      exp_q.push_back({10'(i), img_basic[i]});
      send_byte(img_basic[i], 1'b0);
    end
    send_byte(8'h59, 1'b0);
    check("busy_start_done", done, 1);
    check("busy_start_ok", ok, 1);
    drain();
    check("busy_start_writes", 32'(got_q.size() - g0), 8);
    check("busy_start_exp_empty", 32'(exp_q.size()), 0);

    // reset in the middle of a load
    saved103 = mem[103];
    g0 = got_q.size();
    start_load(10'd100, 11'd8);
    for (int i = 0; i < 3; i++) begin
      bb = 8'(8'hA0 + 8'(i));
      exp_q.push_back({10'(100 + i), bb});
      send_byte(bb, 1'b0);
    end
    sif.s_valid = 1'b1;
    sif.s_data  = 8'hEE;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("midload_reset");
    @(posedge clk);
    @(posedge clk); #1;
    check_reset_vals("midload_reset_held");
    sif.s_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drain();
    check("midload_writes", 32'(got_q.size() - g0), 3);
    check("midload_partial_kept", mem[102], 8'hA2);
    check("midload_no_more", mem[103], saved103);
    check("midload_exp_empty", 32'(exp_q.size()), 0);
    run_vec(vecs[0], "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
